// File: rtl/lsu_ctrl.sv
// Load/store controller: turns byte-addressed, size-tagged requests into word-indexed
// data-memory accesses, with sub-word extraction and read-modify-write for sub-word stores.
module lsu_ctrl #(
    parameter int unsigned MemSize = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespError,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;
    logic [29:0] idx_q, idx_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic        req_err;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign ReqReady  = rst_n && (state_q == StIdle);
    assign RespValid = resp_valid_q;
    assign RespRData = resp_rdata_q;
    assign RespError = resp_error_q;
    assign Address   = mem_addr_q;
    assign WriteData = mem_wdata_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;

    assign req_err = (ReqSize == 2'b11)
                   || ((ReqSize == 2'b01) && ReqAddr[0])
                   || ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00))
                   || ((ReqAddr[31:2] >> MemSize) != 30'd0);

    // Lane extraction and merge both work on the word presented during the READ cycle.
    always_comb begin
        shifted = ReadData >> {lane_q, 3'b000};
        unique case (size_q)
            2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = ReadData;
        endcase
        merged = ReadData;
        if (size_q == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (size_q == 2'b01) begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = 32'd0;
        mem_wdata_d  = 32'd0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        unique case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    lane_d   = ReqAddr[1:0];
                    wdata_d  = ReqWData[15:0];
                    idx_d    = ReqAddr[31:2];
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (ReqWrite && (ReqSize == 2'b10)) begin
                        state_d     = StWrite;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {2'b00, ReqAddr[31:2]};
                        mem_wdata_d = ReqWData;
                    end else begin
                        state_d    = StRead;
                        mem_read_d = 1'b1;
                        mem_addr_d = {2'b00, ReqAddr[31:2]};
                    end
                end
            end
            StRead: begin
                if (write_q) begin
                    state_d     = StWrite;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {2'b00, idx_q};
                    mem_wdata_d = merged;
                end else begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = load_ext;
                end
            end
            StWrite: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'd0;
            end
            StResp: begin
                if (RespReady) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    resp_rdata_d = 32'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'd0;
            idx_q        <= 30'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random requests checked against a word-array reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [31:0] ReqAddr = 32'd0;
    logic [31:0] ReqWData = 32'd0;
    logic        RespValid;
    logic        RespReady = 1'b0;
    logic [31:0] RespRData;
    logic        RespError;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int n_tests = 0;
    int n_fail = 0;

    lsu_ctrl #(.MemSize(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
        .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespReady(RespReady), .RespRData(RespRData),
        .RespError(RespError), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    assign ReadData = MemRead ? mem[Address[5:0]] : 32'h0;
    always @(posedge clk) if (MemWrite) mem[Address[5:0]] <= WriteData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
            || (a / 4) >= 64;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [1:0] sz,
                                             input bit sg, input logic [31:0] a);
        longint v;
        int unsigned k = a % 4;
        if (sz == 2'd0) begin
            v = (word >> (8 * k)) % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (word >> (8 * k)) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = word;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] mask;
        int unsigned k = a % 4;
        if (sz == 2'd0) begin
            mask = 32'hFF << (8 * k);
            return (old & ~mask) | ((wd & 32'hFF) << (8 * k));
        end
        mask = 32'hFFFF << (8 * k);
        return (old & ~mask) | ((wd & 32'hFFFF) << (8 * k));
    endfunction

    task automatic run_req(input bit w, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           input string tag);
        bit err, seen;
        int exp_lat, exp_rd, exp_wr, lat, rd_n, wr_n;
        logic [31:0] exp_r, exp_wd, rd_a, wr_a, wr_d, got_r;
        err = is_err(sz, a);
        exp_r = 32'd0;
        exp_wd = 32'd0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!w) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            exp_r = load_val(ref_mem[a / 4], sz, sg, a);
        end else begin
            exp_wd = (sz == 2'd2) ? wd : store_val(ref_mem[a / 4], wd, sz, a);
            exp_lat = (sz == 2'd2) ? 2 : 3;
            exp_rd = (sz == 2'd2) ? 0 : 1;
            exp_wr = 1;
            ref_mem[a / 4] = exp_wd;
        end

        @(negedge clk);
        chk({tag, "_ready"}, 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
        @(posedge clk);
        #1;
        // Scramble request fields to show they were captured at the accept edge.
        ReqValid = 1'b0; ReqWrite = ~w; ReqSigned = ~sg;
        ReqAddr = $urandom; ReqWData = $urandom; ReqSize = 2'($urandom);

        seen = 0; lat = 0; rd_n = 0; wr_n = 0;
        rd_a = 32'd0; wr_a = 32'd0; wr_d = 32'd0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (MemRead) begin rd_n++; rd_a = Address; end
            if (MemWrite) begin wr_n++; wr_a = Address; wr_d = WriteData; end
            if (RespValid) seen = 1;
        end
        chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_read_cycles"}, 32'(rd_n), 32'(exp_rd));
            chk({tag, "_write_cycles"}, 32'(wr_n), 32'(exp_wr));
            chk({tag, "_error"}, 32'(RespError), 32'(err));
            chk({tag, "_rdata"}, RespRData, exp_r);
            if (exp_rd != 0) chk({tag, "_read_addr"}, rd_a, a / 4);
            if (exp_wr != 0) begin
                chk({tag, "_write_addr"}, wr_a, a / 4);
                chk({tag, "_write_data"}, wr_d, exp_wd);
            end
            got_r = RespRData;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 32'(RespValid), 32'd1);
                chk({tag, "_hold_rdata"}, RespRData, got_r);
                chk({tag, "_hold_ready"}, 32'(ReqReady), 32'd0);
                chk({tag, "_hold_mem_idle"}, 32'({MemRead, MemWrite}), 32'd0);
            end
        end
        RespReady = 1'b1;
        @(posedge clk);
        #1;
        RespReady = 1'b0;
        @(negedge clk);
        chk({tag, "_resp_dropped"}, 32'(RespValid), 32'd0);
        chk({tag, "_ready_again"}, 32'(ReqReady), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        #12;
        chk("rst_req_ready", 32'(ReqReady), 32'd0);
        chk("rst_resp_valid", 32'(RespValid), 32'd0);
        chk("rst_resp_rdata", RespRData, 32'd0);
        chk("rst_resp_error", 32'(RespError), 32'd0);
        chk("rst_address", Address, 32'd0);
        chk("rst_write_data", WriteData, 32'd0);
        chk("rst_mem_en", 32'({MemRead, MemWrite}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(ReqReady), 32'd1);

        run_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, "sw_0x10");
        run_req(0, 2'd2, 1, 32'h10, 32'h0, 0, "lw_0x10");
        chk("lw_const", load_val(ref_mem[4], 2'd2, 1, 32'h10), 32'hDEADBEEF);
        run_req(0, 2'd0, 1, 32'h13, 32'h0, 0, "lb_0x13");
        run_req(0, 2'd0, 0, 32'h12, 32'h0, 0, "lbu_0x12");
        run_req(0, 2'd1, 1, 32'h10, 32'h0, 0, "lh_0x10");
        run_req(1, 2'd0, 0, 32'h11, 32'h55, 0, "sb_0x11");
        run_req(0, 2'd2, 0, 32'h10, 32'h0, 0, "lw_after_sb");
        chk("sb_merge_const", ref_mem[4], 32'hDEAD55EF);
        run_req(0, 2'd1, 1, 32'h11, 32'h0, 0, "err_lh_0x11");
        run_req(1, 2'd2, 0, 32'h12, 32'h12345678, 0, "err_sw_0x12");
        run_req(0, 2'd2, 0, 32'h100, 32'h0, 0, "err_lw_0x100");
        run_req(0, 2'd3, 0, 32'h8, 32'h0, 0, "err_size3");
        run_req(0, 2'd2, 0, 32'h10, 32'h0, 5, "lw_backpressure");

        // Reset in the middle of a sub-word store's WRITE cycle.
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddr = 32'h24; ReqWData = 32'hA5;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_phase", 32'(MemRead), 32'd1);
        @(negedge clk);
        chk("rst_mid_write_phase", 32'(MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_memwrite_drop", 32'(MemWrite), 32'd0);
        chk("rst_mid_memread_drop", 32'(MemRead), 32'd0);
        chk("rst_mid_address", Address, 32'd0);
        chk("rst_mid_ready_low", 32'(ReqReady), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ready_high", 32'(ReqReady), 32'd1);
        RespReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", 32'(RespValid), 32'd0);
            chk("rst_mid_idle_ready", 32'(ReqReady), 32'd1);
        end
        RespReady = 1'b0;

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            logic [1:0] sz;
            logic [31:0] a;
            r = $urandom;
            sz = (r % 8 == 0) ? 2'd3 : 2'(r % 3);
            a = (r % 10 == 1) ? $urandom : $urandom_range(0, 255);
            run_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller that initiates accesses to the data memory on behalf of the datapath.
- Converts byte-addressed, size-tagged load/store requests into the data memory's word-indexed MemRead/MemWrite/Address/WriteData interface.
- Performs sub-word extraction with sign/zero extension, and performs read-modify-write merging for sub-word stores.
- Flags misaligned and out-of-range requests without touching memory.

Parameters:
- MemSize, 6, log2 of data-memory depth in 32-bit words; valid word indices are 0 .. 2^MemSize-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- ReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RespValid  out  1  response present.
- RespReady  in  1  consumer takes the response.
- RespRData  out  32  load result, extended to 32 bits; 0 for stores and errors.
- RespError  out  1  request rejected (misaligned, out of range, or illegal size).
- Address  out  32  word index to data memory, equal to ReqAddr[31:2].
- WriteData  out  32  full word to write.
- MemRead  out  1  read enable.
- MemWrite  out  1  write enable; the memory writes level-sensitively.
- ReadData  in  32  memory read word, combinational from Address while MemRead=1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE immediately.
  - ReqReady=0 while rst_n=0 and 1 after release.
  - RespValid=0, RespRData=0, RespError=0.
  - Address=0, WriteData=0, MemRead=0, MemWrite=0.
  - Reset asserted mid-operation drops MemWrite/MemRead in the same instant; the request is abandoned and no response is issued.
- Memory-side outputs are registered; they are never decoded combinationally from request inputs. Outside READ/WRITE states, all memory-side outputs are 0.
- Handshake:
  - ReqReady=1 only in IDLE.
  - A request is accepted on a rising edge with ReqValid&ReqReady; all Req* fields are captured at that edge.
  - The response holds stable while RespValid=1 && RespReady=0.
  - The FSM returns to IDLE on the edge where RespValid&RespReady.
- Checks at acceptance; any failure sets err and routes the FSM directly to RESP with no memory access:
  - ReqSize=11.
  - Halfword with ReqAddr[0]=1.
  - Word with ReqAddr[1:0]!=0.
  - ReqAddr[31:2] >= 2^MemSize.
- States:
  - IDLE: on accept → RESP (err), READ (load or sub-word store), or WRITE (word store).
  - READ, 1 cycle: MemRead=1, Address=word index. ReadData is captured at the end of the cycle. Next state is RESP for a load, WRITE for a sub-word store.
  - WRITE, exactly 1 cycle:
    - MemWrite=1; Address and WriteData are stable for the whole cycle.
    - Word store: WriteData=ReqWData.
    - Sub-word store: WriteData=captured word with the selected lane replaced.
    - Next state: RESP.
  - RESP: RespValid=1; waits for RespReady.
- Lanes are little-endian:
  - Byte lane k=ReqAddr[1:0] occupies bits [8k+7:8k].
  - Halfword lane ReqAddr[1] occupies bits [16h+15:16h].
- Load extension: ReqSigned replicates the lane MSB; otherwise upper bits are 0. Word loads ignore ReqSigned.
- Latency from accept edge to RespValid: load 2 cycles, word store 2, sub-word store 3, error 1.
- Throughput: one outstanding request; RespReady may be tied to 1.

Test Plan:
- Reset with rst_n=0 mid-WRITE (sub-word store in flight) → MemWrite falls immediately with no clock edge; after release ReqReady=1, RespValid=0, and no response is ever issued.
- Word store 0xDEADBEEF to addr 0x10, then lw signed from 0x10 → MemWrite pulse exactly 1 cycle with Address=4; load RespRData=0xDEADBEEF 2 cycles after accept.
- With word 4 = 0xDEADBEEF:
  - lb signed from addr 0x13 → 0xFFFFFFDE.
  - lbu from addr 0x12 → 0x000000AD.
  - lh signed from addr 0x10 → 0xFFFFBEEF.
- sb 0x55 to addr 0x11 over word 4=0xDEADBEEF → READ cycle, then WRITE with WriteData=0xDEAD55EF; a following lw from 0x10 returns 0xDEAD55EF.
- Errors each give RespError=1 one cycle after accept, with MemRead=MemWrite=0 throughout:
  - lh from 0x11.
  - sw to 0x12.
  - lw from 0x100 (word index 64 ≥ 64).
  - ReqSize=11.
- Backpressure: RespReady=0 for 5 cycles after RespValid on a load → RespRData/RespValid stable and ReqReady=0; accept resumes the cycle after RespReady=1.
